// File: rtl/dsp_io_router.sv
// dsp_io_router: frame-synchronous router between the DSP I/O bus, the ADAT channels and the
// metering memory.
// - DSP reads return a per-frame snapshot of the inputs.
// - DSP writes go to a shadow bank that is committed to the outputs on frame_sync.
// - Writes to the meter region pass through to the meter memory.
// Optional feature macro: DSP_IO_PEAK_METER_EN adds per-channel peak tracking plus a
// per-frame peak dump into the meter memory.
module dsp_io_router #(
    parameter int unsigned IO_WIDTH         = 24,
    parameter int unsigned IO_ADDR_WIDTH    = 10,
    parameter int unsigned NUM_CHANNELS     = 8,
    parameter int unsigned METER_ADDR_WIDTH = 8,
    parameter logic [METER_ADDR_WIDTH-1:0] PEAK_BASE = 8'hF0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             frame_sync,
    input  logic [NUM_CHANNELS*IO_WIDTH-1:0] audio_inputs,
    output logic [NUM_CHANNELS*IO_WIDTH-1:0] audio_outputs,
    input  logic [IO_ADDR_WIDTH-1:0]         io_rd_addr,
    input  logic                             io_rd_en,
    output logic [IO_WIDTH-1:0]              io_rd_data,
    input  logic [IO_ADDR_WIDTH-1:0]         io_wr_addr,
    input  logic [IO_WIDTH-1:0]              io_wr_data,
    input  logic                             io_wr_en,
    output logic [METER_ADDR_WIDTH-1:0]      meter_wr_addr,
    output logic [IO_WIDTH-1:0]              meter_wr_data,
    output logic                             meter_wr_en,
    output logic                             frame_overrun,
    input  logic                             overrun_clr
);

    localparam int unsigned LO_W = IO_ADDR_WIDTH - 1;
    localparam logic [IO_ADDR_WIDTH-1:0] NUM_CH_A = IO_ADDR_WIDTH'(NUM_CHANNELS);

    logic [NUM_CHANNELS-1:0][IO_WIDTH-1:0] snapshot_q;
    logic [NUM_CHANNELS-1:0][IO_WIDTH-1:0] shadow_q;
    logic [NUM_CHANNELS-1:0][IO_WIDTH-1:0] outputs_q;
    logic [IO_WIDTH-1:0]                   rd_data_q;
    logic [IO_WIDTH-1:0]                   rd_word;
    logic [LO_W-1:0]                       rd_lo;
    logic [LO_W-1:0]                       wr_lo;
    logic                                  rd_adat;
    logic                                  wr_adat;
    logic                                  wr_meter;
    logic [NUM_CHANNELS-1:0]               wr_sel;
    logic [METER_ADDR_WIDTH-1:0]           meter_addr_q;
    logic [IO_WIDTH-1:0]                   meter_data_q;
    logic                                  meter_en_q;

    assign rd_lo    = io_rd_addr[LO_W-1:0];
    assign wr_lo    = io_wr_addr[LO_W-1:0];
    assign rd_adat  = !io_rd_addr[IO_ADDR_WIDTH-1] && ({1'b0, rd_lo} < NUM_CH_A);
    assign wr_adat  = io_wr_en && !io_wr_addr[IO_ADDR_WIDTH-1] && ({1'b0, wr_lo} < NUM_CH_A);
    assign wr_meter = io_wr_en && io_wr_addr[IO_ADDR_WIDTH-1];

    // Decode read mux and one-hot write select over the ADAT channels
    always_comb begin
        rd_word = '0;
        wr_sel  = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (rd_adat && (rd_lo == LO_W'(c))) rd_word = snapshot_q[c];
            wr_sel[c] = wr_adat && (wr_lo == LO_W'(c));
        end
    end

    // Snapshot/commit on frame_sync; shadow writes land after the commit samples the old value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snapshot_q <= '0;
            shadow_q   <= '0;
            outputs_q  <= '0;
        end else begin
            if (frame_sync) begin
                snapshot_q <= audio_inputs;
                outputs_q  <= shadow_q;
            end
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (wr_sel[c]) shadow_q[c] <= io_wr_data;
            end
        end
    end

    // Registered read port; holds while io_rd_en is low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if (io_rd_en) begin
            rd_data_q <= rd_word;
        end
    end

`ifdef DSP_IO_PEAK_METER_EN
    localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [0:0] {StIdle, StDump} state_e;

    state_e                                state_q;
    logic [CH_W-1:0]                       ch_q;
    logic [NUM_CHANNELS-1:0][IO_WIDTH-1:0] peak_q;
    logic [NUM_CHANNELS-1:0][IO_WIDTH-1:0] dump_q;
    logic                                  overrun_q;
    logic [IO_WIDTH-1:0]                   wr_abs;

    // Saturating magnitude: the most negative code maps to the largest positive one
    always_comb begin
        wr_abs = io_wr_data;
        if (io_wr_data[IO_WIDTH-1]) begin
            if (io_wr_data == {1'b1, {(IO_WIDTH-1){1'b0}}}) begin
                wr_abs = {1'b0, {(IO_WIDTH-1){1'b1}}};
            end else begin
                wr_abs = ~io_wr_data + 1'b1;
            end
        end
    end

    // Per-frame peak tracking; a write in the frame_sync cycle seeds the new frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (frame_sync) begin
                    peak_q[c] <= wr_sel[c] ? wr_abs : '0;
                end else if (wr_sel[c] && (wr_abs > peak_q[c])) begin
                    peak_q[c] <= wr_abs;
                end
            end
        end
    end

    // Dump FSM with registered meter port; DSP passthrough pre-empts the dump for a cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            ch_q         <= '0;
            dump_q       <= '0;
            overrun_q    <= 1'b0;
            meter_en_q   <= 1'b0;
            meter_addr_q <= '0;
            meter_data_q <= '0;
        end else begin
            meter_en_q <= 1'b0;
            if (wr_meter) begin
                meter_en_q   <= 1'b1;
                meter_addr_q <= io_wr_addr[METER_ADDR_WIDTH-1:0];
                meter_data_q <= io_wr_data;
            end
            if (frame_sync && (state_q == StDump)) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end
            if (frame_sync) begin
                dump_q  <= peak_q;
                ch_q    <= '0;
                state_q <= StDump;
            end else if ((state_q == StDump) && !wr_meter) begin
                meter_en_q   <= 1'b1;
                meter_addr_q <= PEAK_BASE + METER_ADDR_WIDTH'(ch_q);
                meter_data_q <= dump_q[ch_q];
                ch_q         <= ch_q + 1'b1;
                if (ch_q == CH_W'(NUM_CHANNELS - 1)) state_q <= StIdle;
            end
        end
    end

    assign frame_overrun = overrun_q;
`else
    logic unused_overrun_clr;

    assign unused_overrun_clr = overrun_clr;

    // Registered meter passthrough only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meter_en_q   <= 1'b0;
            meter_addr_q <= '0;
            meter_data_q <= '0;
        end else begin
            meter_en_q <= wr_meter;
            if (wr_meter) begin
                meter_addr_q <= io_wr_addr[METER_ADDR_WIDTH-1:0];
                meter_data_q <= io_wr_data;
            end
        end
    end

    assign frame_overrun = 1'b0;
`endif

    assign audio_outputs = outputs_q;
    assign io_rd_data    = rd_data_q;
    assign meter_wr_addr = meter_addr_q;
    assign meter_wr_data = meter_data_q;
    assign meter_wr_en   = meter_en_q;

endmodule

// File: tb/tb_dsp_io_router.sv
// tb_dsp_io_router: directed self-checking bench for dsp_io_router (default parameters).
// Define DSP_IO_PEAK_METER_EN to also exercise the peak dump.
module tb_dsp_io_router;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             frame_sync;
    logic [7:0][23:0] ain;
    logic [7:0][23:0] aout;
    logic [9:0]       io_rd_addr;
    logic             io_rd_en;
    logic [23:0]      io_rd_data;
    logic [9:0]       io_wr_addr;
    logic [23:0]      io_wr_data;
    logic             io_wr_en;
    logic [7:0]       meter_wr_addr;
    logic [23:0]      meter_wr_data;
    logic             meter_wr_en;
    logic             frame_overrun;
    logic             overrun_clr;

    int vectors     = 0;
    int miscompares = 0;

    dsp_io_router dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .frame_sync    (frame_sync),
        .audio_inputs  (ain),
        .audio_outputs (aout),
        .io_rd_addr    (io_rd_addr),
        .io_rd_en      (io_rd_en),
        .io_rd_data    (io_rd_data),
        .io_wr_addr    (io_wr_addr),
        .io_wr_data    (io_wr_data),
        .io_wr_en      (io_wr_en),
        .meter_wr_addr (meter_wr_addr),
        .meter_wr_data (meter_wr_data),
        .meter_wr_en   (meter_wr_en),
        .frame_overrun (frame_overrun),
        .overrun_clr   (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_meter(input string tag, input logic en, input logic [7:0] addr,
                             input logic [23:0] data);
        chk({tag, ".en"}, meter_wr_en, en);
        if (en) begin
            chk({tag, ".addr"}, meter_wr_addr, addr);
            chk({tag, ".data"}, meter_wr_data, data);
        end
    endtask

    initial begin
        logic [7:0][23:0] exp_out;
        reset_n     = 1'b0;
        frame_sync  = 1'b0;
        ain         = '0;
        io_rd_addr  = '0;
        io_rd_en    = 1'b0;
        io_wr_addr  = '0;
        io_wr_data  = '0;
        io_wr_en    = 1'b0;
        overrun_clr = 1'b0;
        exp_out     = '0;

        // Reset state
        tick();
        tick();
        chk("rst.outputs", aout, '0);
        chk("rst.rd_data", io_rd_data, 24'h0);
        chk_meter("rst.meter", 1'b0, 8'h0, 24'h0);
        chk("rst.meter_addr", meter_wr_addr, 8'h0);
        chk("rst.overrun", frame_overrun, 1'b0);
        reset_n = 1'b1;
        tick();

        io_rd_en   = 1'b1;
        io_rd_addr = 10'd0;
        tick();
        chk("rd.addr0_idle", io_rd_data, 24'h0);
        io_rd_en = 1'b0;

        // Snapshot capture
        ain[3]     = 24'h123456;
        ain[0]     = 24'h0000AA;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        ain[3]     = 24'h000001;
        io_rd_en   = 1'b1;
        io_rd_addr = 10'd3;
        tick();
        chk("rd.snap_ch3", io_rd_data, 24'h123456);
        io_rd_en   = 1'b0;
        io_rd_addr = 10'd9;
        tick();
        chk("rd.hold", io_rd_data, 24'h123456);
        io_rd_en = 1'b1;
        tick();
        chk("rd.unmapped9", io_rd_data, 24'h0);
        io_rd_addr = 10'd0;
        tick();
        chk("rd.snap_ch0", io_rd_data, 24'h0000AA);
        io_rd_addr = 10'h203;
        tick();
        chk("rd.meter_region", io_rd_data, 24'h0);
        // Read coincident with frame_sync sees the previous frame
        io_rd_addr = 10'd3;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        chk("rd.same_cycle_fs", io_rd_data, 24'h123456);
        tick();
        chk("rd.new_frame", io_rd_data, 24'h000001);
        io_rd_en = 1'b0;

        // Shadow bank and commit
        io_wr_en   = 1'b1;
        io_wr_addr = 10'd5;
        io_wr_data = 24'hABCDEF;
        tick();
        io_wr_en = 1'b0;
        chk("wr.uncommitted", aout[5], 24'h0);
        chk("wr.adat_not_meter", meter_wr_en, 1'b0);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        chk("wr.commit_ch5", aout[5], 24'hABCDEF);
        io_wr_en   = 1'b1;
        io_wr_data = 24'h111111;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        io_wr_en   = 1'b0;
        chk("wr.same_cycle_fs", aout[5], 24'hABCDEF);
        tick();
        chk("wr.still_old", aout[5], 24'hABCDEF);
        io_wr_en   = 1'b1;
        io_wr_addr = 10'd9;
        io_wr_data = 24'h999999;
        tick();
        io_wr_en   = 1'b0;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        exp_out[5] = 24'h111111;
        chk("wr.next_frame_all", aout, exp_out);
        tick();
        chk("wr.persist", aout, exp_out);

`ifndef DSP_IO_PEAK_METER_EN
        chk("cfg.no_dump", meter_wr_en, 1'b0);
        chk("cfg.overrun_tied", frame_overrun, 1'b0);
`endif
        repeat (12) tick();

        // Meter passthrough
        io_wr_en   = 1'b1;
        io_wr_addr = 10'h205;
        io_wr_data = 24'h000042;
        tick();
        io_wr_en = 1'b0;
        chk_meter("meter.pass", 1'b1, 8'h05, 24'h000042);
        tick();
        chk("meter.pass_done", meter_wr_en, 1'b0);

`ifdef DSP_IO_PEAK_METER_EN
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("pk.overrun_cleared", frame_overrun, 1'b0);

        // Peak tracking with saturation, then a dump stalled by one DSP meter write
        io_wr_en   = 1'b1;
        io_wr_addr = 10'd0;
        io_wr_data = 24'h000010;
        tick();
        io_wr_data = 24'hFFFF00;
        tick();
        io_wr_data = 24'h800000;
        tick();
        io_wr_en   = 1'b0;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        tick();
        chk_meter("pk.dump0", 1'b1, 8'hF0, 24'h7FFFFF);
        io_wr_en   = 1'b1;
        io_wr_addr = 10'h2AA;
        io_wr_data = 24'h000055;
        tick();
        io_wr_en = 1'b0;
        chk_meter("pk.stall_pass", 1'b1, 8'hAA, 24'h000055);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_meter($sformatf("pk.dump%0d", i), 1'b1, 8'hF0 + 8'(i), 24'h0);
        end
        tick();
        chk("pk.dump_end", meter_wr_en, 1'b0);
        chk("pk.no_overrun", frame_overrun, 1'b0);

        // Overrun: frame_sync three cycles into a dump; seed write rides the first frame_sync
        io_wr_en   = 1'b1;
        io_wr_addr = 10'd2;
        io_wr_data = 24'h000033;
        frame_sync = 1'b1;
        tick();
        io_wr_en   = 1'b0;
        frame_sync = 1'b0;
        tick();
        chk_meter("ov.first0", 1'b1, 8'hF0, 24'h0);
        tick();
        chk_meter("ov.first1", 1'b1, 8'hF1, 24'h0);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        chk("ov.abandon", meter_wr_en, 1'b0);
        chk("ov.set", frame_overrun, 1'b1);
        tick();
        chk_meter("ov.restart0", 1'b1, 8'hF0, 24'h0);
        tick();
        chk_meter("ov.restart1", 1'b1, 8'hF1, 24'h0);
        tick();
        chk_meter("ov.seed2", 1'b1, 8'hF2, 24'h000033);
        repeat (6) tick();
        chk("ov.sticky", frame_overrun, 1'b1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ov.clr", frame_overrun, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
